// File: rtl/apb_sfr_bank_dbuf_pkg.sv
// Shared types and constants for the double-buffered APB SFR bank.
// The optional IRQ feature is enabled with the APB_SFR_IRQ_EN macro.
package apb_sfr_pkg;

  localparam int unsigned APB_AW = 32;
  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_SW = APB_DW / 8;

  localparam int unsigned ACT_BASE_DEF = 32'h100;
  localparam int unsigned CTRL_OFS_DEF = 32'h80;

  localparam int unsigned CTRL_ARM     = 0;
  localparam int unsigned CTRL_FORCE   = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_CMT_STS = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} xfer_state_e;

  typedef enum logic [1:0] {SHADOW, CTRL, ACTIVE, ERR} dec_e;

  // Request captured in the access phase
  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
    logic [APB_SW-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/apb_sfr_bank_dbuf_if.sv
// APB bus bundle between the master and the SFR bank.
interface apb_sfr_bank_dbuf_if;
  import apb_sfr_pkg::*;

  logic              i_PSEL;
  logic              i_PEN;
  logic              i_PWRITE;
  logic [APB_AW-1:0] i_PADDR;
  logic [APB_DW-1:0] i_PWDATA;
  logic [APB_SW-1:0] i_PSTRB;
  logic [APB_DW-1:0] o_PRDATA;
  logic              o_PREADY;
  logic              o_PSLVERR;

  modport master (
    output i_PSEL, i_PEN, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
    input  o_PRDATA, o_PREADY, o_PSLVERR
  );

  modport slave (
    input  i_PSEL, i_PEN, i_PWRITE, i_PADDR, i_PWDATA, i_PSTRB,
    output o_PRDATA, o_PREADY, o_PSLVERR
  );
endinterface

// File: rtl/apb_sfr_bank_dbuf_xfer_fsm.sv
// APB transfer sequencer: wait-state counter, PREADY and the single-cycle
// access strobe on which the register bank applies side effects.
module apb_sfr_xfer_fsm
  import apb_sfr_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic psel_i,
  input  logic pen_i,
  output logic cap_o,
  output logic acc_o,
  output logic pready_o
);

  localparam int unsigned CNT_W = 4;

  xfer_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= (state_d == RESP);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (psel_i && pen_i) begin
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) state_d = RESP;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture on the PEN cycle; access strobe on the edge that enters RESP
  always_comb begin
    cap_o = (state_q == IDLE) && psel_i && pen_i;
    acc_o = (state_d == RESP);
  end

  assign pready_o = pready_q;

endmodule

// File: rtl/apb_sfr_bank_dbuf.sv
// APB shadow/active SFR bank: software programs shadow, a commit copies it to
// active at frame start or on force. APB_SFR_IRQ_EN adds a commit interrupt.
module apb_sfr_bank_dbuf
  import apb_sfr_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ACT_BASE    = ACT_BASE_DEF,
  parameter int unsigned CTRL_OFS    = CTRL_OFS_DEF
) (
  input  logic                       PCLK,
  input  logic                       PRSTN,
  apb_sfr_bank_dbuf_if.slave         apb,
  input  logic                       i_frame_start,
  output logic [NUM_REGS*DATA_W-1:0] o_active,
  output logic                       o_commit_done,
  output logic                       o_pending
`ifdef APB_SFR_IRQ_EN
  ,
  output logic                       o_irq
`endif
);

  localparam int unsigned      IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned      NBYTES    = DATA_W / 8;
  localparam logic [APB_AW-1:0] WIN_BYTES = APB_AW'(NUM_REGS * 4);

  logic              cap_c, acc_c, pready_c, copy_c, err_c;
  apb_req_t          req_q, req_c;
  dec_e              dec_c;
  logic [IDX_W-1:0]  idx_c;
  logic [APB_AW-1:0] act_off_c;
  logic [APB_DW-1:0] rdata_c, ctrl_rd_c;

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] active_d [NUM_REGS];
  logic              pending_q, pending_d;
  logic              force_q, force_d;
  logic              commit_q, commit_d;
  logic              pslverr_q, pslverr_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
`ifdef APB_SFR_IRQ_EN
  logic              irq_en_q, irq_en_d;
  logic              sts_q, sts_d;
  logic              irq_q, irq_d;
`endif

  apb_sfr_xfer_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_xfer_fsm (
    .clk_i    (PCLK),
    .rst_ni   (PRSTN),
    .psel_i   (apb.i_PSEL),
    .pen_i    (apb.i_PEN),
    .cap_o    (cap_c),
    .acc_o    (acc_c),
    .pready_o (pready_c)
  );

  // With zero wait states the access edge is also the capture edge
  always_comb begin
    req_c = req_q;
    if (cap_c) begin
      req_c.write = apb.i_PWRITE;
      req_c.addr  = apb.i_PADDR;
      req_c.wdata = apb.i_PWDATA;
      req_c.strb  = apb.i_PSTRB;
    end
  end

  always_comb begin
    dec_c     = ERR;
    idx_c     = '0;
    act_off_c = req_c.addr - APB_AW'(ACT_BASE);
    if (req_c.addr[1:0] != 2'b00) begin
      dec_c = ERR;
    end else if (req_c.addr < WIN_BYTES) begin
      dec_c = SHADOW;
      idx_c = req_c.addr[2 +: IDX_W];
    end else if (req_c.addr == APB_AW'(CTRL_OFS)) begin
      dec_c = CTRL;
    end else if ((req_c.addr >= APB_AW'(ACT_BASE)) && (act_off_c < WIN_BYTES)) begin
      dec_c = ACTIVE;
      idx_c = act_off_c[2 +: IDX_W];
    end
  end

  assign err_c = (dec_c == ERR)
               | (req_c.write & (dec_c == ACTIVE))
               | (req_c.write & (req_c.strb == '0));

  always_comb begin
    ctrl_rd_c           = '0;
    ctrl_rd_c[CTRL_ARM] = pending_q;
`ifdef APB_SFR_IRQ_EN
    ctrl_rd_c[CTRL_IRQ_EN]  = irq_en_q;
    ctrl_rd_c[CTRL_CMT_STS] = sts_q;
`endif
    case (dec_c)
      SHADOW:  rdata_c = APB_DW'(shadow_q[idx_c]);
      CTRL:    rdata_c = ctrl_rd_c;
      ACTIVE:  rdata_c = APB_DW'(active_q[idx_c]);
      default: rdata_c = '0;
    endcase
  end

  assign copy_c = force_q | (i_frame_start & pending_q);

  // Copy uses pre-write shadow; an arm in the same cycle re-sets pending
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    force_d   = 1'b0;
    commit_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
`ifdef APB_SFR_IRQ_EN
    irq_en_d  = irq_en_q;
    sts_d     = sts_q;
`endif
    if (copy_c) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      commit_d  = 1'b1;
    end
    if (acc_c) begin
      pslverr_d = err_c;
      if (!req_c.write && !err_c) prdata_d = rdata_c;
      if (req_c.write && !err_c) begin
        if (dec_c == SHADOW) begin
          for (int b = 0; b < NBYTES; b++) begin
            if (req_c.strb[b]) shadow_d[idx_c][8*b +: 8] = req_c.wdata[8*b +: 8];
          end
        end else if (dec_c == CTRL) begin
          if (req_c.strb[0]) begin
            if (req_c.wdata[CTRL_ARM]) pending_d = 1'b1;
            force_d = req_c.wdata[CTRL_FORCE];
`ifdef APB_SFR_IRQ_EN
            irq_en_d = req_c.wdata[CTRL_IRQ_EN];
`endif
          end
`ifdef APB_SFR_IRQ_EN
          if (req_c.strb[1] && req_c.wdata[CTRL_CMT_STS]) sts_d = 1'b0;
`endif
        end
      end
    end
`ifdef APB_SFR_IRQ_EN
    if (copy_c) sts_d = 1'b1;
    irq_d = irq_en_d & sts_d;
`endif
  end

  always_ff @(posedge PCLK or negedge PRSTN) begin
    if (!PRSTN) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      req_q     <= '0;
      pending_q <= 1'b0;
      force_q   <= 1'b0;
      commit_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_SFR_IRQ_EN
      irq_en_q  <= 1'b0;
      sts_q     <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      if (cap_c) req_q <= req_c;
      pending_q <= pending_d;
      force_q   <= force_d;
      commit_q  <= commit_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_SFR_IRQ_EN
      irq_en_q  <= irq_en_d;
      sts_q     <= sts_d;
      irq_q     <= irq_d;
`endif
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_act
    assign o_active[k*DATA_W +: DATA_W] = active_q[k];
  end

  assign apb.o_PRDATA  = prdata_q;
  assign apb.o_PREADY  = pready_c;
  assign apb.o_PSLVERR = pslverr_q;
  assign o_commit_done = commit_q;
  assign o_pending     = pending_q;
`ifdef APB_SFR_IRQ_EN
  assign o_irq         = irq_q;
`endif

endmodule

// File: tb/tb_apb_sfr_bank_dbuf.sv
// Directed bench for apb_sfr_bank_dbuf: a vector table of APB accesses plus
// hand sequences for commit timing, simultaneous events and mid-transfer reset.
module tb_apb_sfr_bank_dbuf;
  import apb_sfr_pkg::*;

  localparam int unsigned NUM_REGS = 8;
  localparam logic [31:0] CTL      = 32'h80;
  localparam logic [31:0] ACT      = 32'h100;

  logic                     PCLK = 1'b0;
  logic                     PRSTN = 1'b0;
  logic                     frame_start = 1'b0;
  logic [NUM_REGS*32-1:0]   active;
  logic                     commit_done;
  logic                     pending;
`ifdef APB_SFR_IRQ_EN
  logic                     irq;
`endif

  apb_sfr_bank_dbuf_if bus ();

  apb_sfr_bank_dbuf #(
    .NUM_REGS    (NUM_REGS),
    .DATA_W      (32),
    .WAIT_CYCLES (1),
    .ACT_BASE    (32'h100),
    .CTRL_OFS    (32'h80)
  ) dut (
    .PCLK          (PCLK),
    .PRSTN         (PRSTN),
    .apb           (bus),
    .i_frame_start (frame_start),
    .o_active      (active),
    .o_commit_done (commit_done),
    .o_pending     (pending)
`ifdef APB_SFR_IRQ_EN
    ,
    .o_irq         (irq)
`endif
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  int          nerr = 0;
  int          nchk = 0;
  int          cd_cnt = 0;
  int          cd0;
  logic [31:0] rd;
  logic        er;
  int          lat;

  always @(negedge PCLK) if (commit_done === 1'b1) cd_cnt++;

  function automatic logic [31:0] areg(input int k);
    return active[k*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 'h%08h, expected 'h%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb,
                     input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.strb = strb; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // fs_cyc: cycle (0 = PEN cycle) during which frame_start is high, -1 for none
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int fs_cyc,
                     output logic [31:0] rdata, output logic err, output int latency);
    @(posedge PCLK); #1;
    bus.i_PSEL = 1'b1; bus.i_PEN = 1'b0; bus.i_PWRITE = wr;
    bus.i_PADDR = addr; bus.i_PWDATA = wdata; bus.i_PSTRB = strb;
    @(posedge PCLK); #1;
    bus.i_PEN = 1'b1;
    frame_start = (fs_cyc == 0);
    latency = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge PCLK); #1;
      frame_start = (n == fs_cyc);
      if (bus.o_PREADY === 1'b1) begin
        latency = n;
        break;
      end
    end
    rdata = bus.o_PRDATA;
    err   = bus.o_PSLVERR;
    @(posedge PCLK); #1;
    bus.i_PSEL = 1'b0; bus.i_PEN = 1'b0; frame_start = 1'b0;
  endtask

  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input int fs_cyc,
                      input logic [31:0] exp_rd, input logic exp_err);
    apb(wr, addr, wdata, strb, fs_cyc, rd, er, lat);
    chk({name, "_lat"}, 32'(lat), 32'd2);
    chk({name, "_err"}, 32'(er), 32'(exp_err));
    chk({name, "_rd"}, rd, exp_rd);
  endtask

  task automatic pulse_fs();
    @(posedge PCLK); #1; frame_start = 1'b1;
    @(posedge PCLK); #1; frame_start = 1'b0;
  endtask

  initial begin
    bus.i_PSEL = 1'b0; bus.i_PEN = 1'b0; bus.i_PWRITE = 1'b0;
    bus.i_PADDR = '0; bus.i_PWDATA = '0; bus.i_PSTRB = '0;

    add("wr_s1_strb",  1'b1, 32'h4,  32'hDEADBEEF, 4'b0101, 32'h0,        1'b0);
    add("rd_s1",       1'b0, 32'h4,  32'h0,        4'h0,    32'h00AD00EF, 1'b0);
    add("rd_a1_old",   1'b0, ACT+4,  32'h0,        4'h0,    32'h0,        1'b0);
    add("rd_unalign",  1'b0, 32'h2,  32'h0,        4'h0,    32'h0,        1'b1);
    add("rd_unmap40",  1'b0, 32'h40, 32'h0,        4'h0,    32'h0,        1'b1);
    add("wr_act",      1'b1, ACT,    32'h12345678, 4'hF,    32'h0,        1'b1);
    add("wr_strb0",    1'b1, 32'h0,  32'h12345678, 4'h0,    32'h0,        1'b1);
    add("rd_s0_kept",  1'b0, 32'h0,  32'h0,        4'h0,    32'h0,        1'b0);
    add("rd_a0_kept",  1'b0, ACT,    32'h0,        4'h0,    32'h0,        1'b0);
    add("wr_s7",       1'b1, 32'h1C, 32'hA5A5A5A5, 4'hF,    32'h0,        1'b0);
    add("rd_s7",       1'b0, 32'h1C, 32'h0,        4'hF,    32'hA5A5A5A5, 1'b0);
    add("rd_act_end",  1'b0, ACT+32, 32'h0,        4'h0,    32'h0,        1'b1);
    add("rd_unmap7c",  1'b0, 32'h7C, 32'h0,        4'h0,    32'h0,        1'b1);
    add("rd_unmap84",  1'b0, 32'h84, 32'h0,        4'h0,    32'h0,        1'b1);
    add("wr_s0",       1'b1, 32'h0,  32'hCAFEF00D, 4'hF,    32'h0,        1'b0);
    add("rd_ctl_0",    1'b0, CTL,    32'h0,        4'h0,    32'h0,        1'b0);
    add("wr_ctl_arm",  1'b1, CTL,    32'h1,        4'hF,    32'h0,        1'b0);
    add("rd_ctl_1",    1'b0, CTL,    32'h0,        4'h0,    32'h1,        1'b0);

    // Reset state
    repeat (3) @(posedge PCLK); #1;
    chk("rst_pready",  32'(bus.o_PREADY), 32'd0);
    chk("rst_prdata",  bus.o_PRDATA, 32'h0);
    chk("rst_pslverr", 32'(bus.o_PSLVERR), 32'd0);
    chk("rst_commit",  32'(commit_done), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_active",  32'(|active), 32'd0);
    PRSTN = 1'b1;
    idle(2);

    // PSEL without PEN leaves the FSM idle
    bus.i_PSEL = 1'b1; bus.i_PADDR = 32'h4;
    idle(1);
    bus.i_PSEL = 1'b0;
    idle(2);
    chk("psel_only_pready", 32'(bus.o_PREADY), 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      xfer(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, -1,
           vecs[i].exp_rd, vecs[i].exp_err);
    chk("tbl_pending", 32'(pending), 32'd1);
    chk("tbl_active0", 32'(|active), 32'd0);

    // Frame-start commit of the armed shadow set
    cd0 = cd_cnt;
    pulse_fs();
    chk("fs_commit_done", 32'(commit_done), 32'd1);
    chk("fs_pending",     32'(pending), 32'd0);
    chk("fs_active0",     areg(0), 32'hCAFEF00D);
    chk("fs_active1",     areg(1), 32'h00AD00EF);
    chk("fs_active7",     areg(7), 32'hA5A5A5A5);
    idle(1);
    chk("fs_commit_pulse", 32'(commit_done), 32'd0);
    xfer("rd_a1_new", 1'b0, ACT+4, 32'h0, 4'h0, -1, 32'h00AD00EF, 1'b0);
    chk("fs_cd_count", 32'(cd_cnt - cd0), 32'd1);

    // Frame start without pending does nothing
    cd0 = cd_cnt;
    pulse_fs();
    idle(2);
    chk("fs_idle_cd", 32'(cd_cnt - cd0), 32'd0);

    // Shadow write coinciding with commit
    xfer("wr_s0_22", 1'b1, 32'h0, 32'h22222222, 4'hF, -1, 32'h0, 1'b0);
    xfer("arm_d",    1'b1, CTL,   32'h1,        4'hF, -1, 32'h0, 1'b0);
    cd0 = cd_cnt;
    xfer("wr_s0_11", 1'b1, 32'h0, 32'h11111111, 4'hF, 1,  32'h0, 1'b0);
    chk("sim_active0", areg(0), 32'h22222222);
    chk("sim_pending", 32'(pending), 32'd0);
    xfer("sim_rd_s0", 1'b0, 32'h0, 32'h0, 4'h0, -1, 32'h11111111, 1'b0);
    xfer("sim_rd_a0", 1'b0, ACT,   32'h0, 4'h0, -1, 32'h22222222, 1'b0);
    chk("sim_cd_count", 32'(cd_cnt - cd0), 32'd1);

    // Arm in the same cycle as a commit: arm wins
    xfer("arm_e1", 1'b1, CTL, 32'h1, 4'hF, -1, 32'h0, 1'b0);
    cd0 = cd_cnt;
    xfer("arm_e2", 1'b1, CTL, 32'h1, 4'hF, 1,  32'h0, 1'b0);
    idle(2);
    chk("arm_win_pending", 32'(pending), 32'd1);
    chk("arm_win_cd",      32'(cd_cnt - cd0), 32'd1);
    pulse_fs();
    chk("arm_win_clear",   32'(pending), 32'd0);
    chk("arm_win_active0", areg(0), 32'h11111111);

    // Forced copy with nothing pending
    xfer("wr_s2_33", 1'b1, 32'h8, 32'h33333333, 4'hF, -1, 32'h0, 1'b0);
    cd0 = cd_cnt;
    xfer("force", 1'b1, CTL, 32'h2, 4'hF, -1, 32'h0, 1'b0);
    chk("force_commit",  32'(commit_done), 32'd1);
    chk("force_pending", 32'(pending), 32'd0);
    chk("force_active2", areg(2), 32'h33333333);
    xfer("force_rd_ctl", 1'b0, CTL, 32'h0, 4'h0, -1, 32'h0, 1'b0);
    chk("force_cd", 32'(cd_cnt - cd0), 32'd1);

    // Force and frame start together: a single copy
    xfer("wr_s2_44", 1'b1, 32'h8, 32'h44444444, 4'hF, -1, 32'h0, 1'b0);
    xfer("arm_g",    1'b1, CTL,   32'h1,        4'hF, -1, 32'h0, 1'b0);
    cd0 = cd_cnt;
    xfer("force_fs", 1'b1, CTL,   32'h2,        4'hF, 2,  32'h0, 1'b0);
    idle(3);
    chk("force_fs_cd",      32'(cd_cnt - cd0), 32'd1);
    chk("force_fs_active2", areg(2), 32'h44444444);
    chk("force_fs_pending", 32'(pending), 32'd0);

`ifdef APB_SFR_IRQ_EN
    chk("irq_off", 32'(irq), 32'd0);
    xfer("irq_en",   1'b1, CTL, 32'h4,   4'hF, -1, 32'h0,   1'b0);
    chk("irq_on_sticky", 32'(irq), 32'd1);
    xfer("irq_rd",   1'b0, CTL, 32'h0,   4'h0, -1, 32'h104, 1'b0);
    xfer("irq_w1c",  1'b1, CTL, 32'h104, 4'hF, -1, 32'h0,   1'b0);
    chk("irq_cleared", 32'(irq), 32'd0);
    xfer("irq_arm",  1'b1, CTL, 32'h5,   4'hF, -1, 32'h0,   1'b0);
    pulse_fs();
    chk("irq_commit", 32'(irq), 32'd1);
    xfer("irq_clr",  1'b1, CTL, 32'h100, 4'hF, -1, 32'h0,   1'b0);
    chk("irq_clr_done", 32'(irq), 32'd0);
`else
    xfer("ctl_hi_wr", 1'b1, CTL, 32'h104, 4'hF, -1, 32'h0, 1'b0);
    xfer("ctl_hi_rd", 1'b0, CTL, 32'h0,   4'h0, -1, 32'h0, 1'b0);
`endif

    // Reset during the wait state of a write aborts it
    @(posedge PCLK); #1;
    bus.i_PSEL = 1'b1; bus.i_PEN = 1'b0; bus.i_PWRITE = 1'b1;
    bus.i_PADDR = 32'h8; bus.i_PWDATA = 32'h55555555; bus.i_PSTRB = 4'hF;
    @(posedge PCLK); #1;
    bus.i_PEN = 1'b1;
    @(posedge PCLK); #1;
    PRSTN = 1'b0;
    #2;
    chk("mid_rst_pready",  32'(bus.o_PREADY), 32'd0);
    chk("mid_rst_prdata",  bus.o_PRDATA, 32'h0);
    chk("mid_rst_pslverr", 32'(bus.o_PSLVERR), 32'd0);
    chk("mid_rst_commit",  32'(commit_done), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    chk("mid_rst_active",  32'(|active), 32'd0);
    bus.i_PSEL = 1'b0; bus.i_PEN = 1'b0;
    @(posedge PCLK); #1;
    PRSTN = 1'b1;
    idle(2);
    xfer("post_rst_rd_s2", 1'b0, 32'h8, 32'h0,        4'h0, -1, 32'h0,        1'b0);
    xfer("post_rst_wr_s2", 1'b1, 32'h8, 32'h66666666, 4'hF, -1, 32'h0,        1'b0);
    xfer("post_rst_rd2",   1'b0, 32'h8, 32'h0,        4'h0, -1, 32'h66666666, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
